display_scan_7seg: RTL

- Four-digit multiplexed seven-segment display driver for the calculator.
- Sits directly downstream of the 500 Hz divider. It consumes the divider's square-wave output as a scan strobe and drives the board's common-anode display.
- Each rising edge of the strobe advances to the next digit. A short all-off blanking gap precedes each digit to suppress ghosting.
- Displayed data is snapshotted once per frame so the display never shows a half-updated value.

---
 rtl/display_scan_7seg_pkg.sv | 13 +
 rtl/display_scan_7seg_if.sv | 19 +
 rtl/display_scan_7seg_hex_to_7seg.sv | 29 ++
 rtl/display_scan_7seg.sv | 97 +++++++++
 4 files changed

// File: rtl/display_scan_7seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan driver.
package display_scan_7seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam int         BLANK_CNT_W = 16;

endpackage

// File: rtl/display_scan_7seg_if.sv
// Data in / display pins out of the scan driver; master is the data source.
interface display_scan_7seg_if;
  logic        scan_in;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  anode_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  modport master (
    output scan_in, value, dp_in,
    input  anode_n, seg_n, dp_n
  );

  modport slave (
    input  scan_in, value, dp_in,
    output anode_n, seg_n, dp_n
  );
endinterface

// File: rtl/display_scan_7seg_hex_to_7seg.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = 7'b1111111;
    case (nibble)
      4'h0: seg_n = 7'b1000000;
      4'h1: seg_n = 7'b1111001;
      4'h2: seg_n = 7'b0100100;
      4'h3: seg_n = 7'b0110000;
      4'h4: seg_n = 7'b0011001;
      4'h5: seg_n = 7'b0010010;
      4'h6: seg_n = 7'b0000010;
      4'h7: seg_n = 7'b1111000;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0010000;
      4'hA: seg_n = 7'b0001000;
      4'hB: seg_n = 7'b0000011;
      4'hC: seg_n = 7'b1000110;
      4'hD: seg_n = 7'b0100001;
      4'hE: seg_n = 7'b0000110;
      default: seg_n = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/display_scan_7seg.sv
// Four-digit common-anode scan driver: one digit per strobe rising edge,
// preceded by an all-off blanking gap; data snapshotted once per frame.
module display_scan_7seg
  import display_scan_7seg_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          LZ_SUPPRESS  = 1'b0
) (
  input logic                clock_in,
  input logic                reset_n,
  display_scan_7seg_if.slave bus
);

  localparam logic [BLANK_CNT_W-1:0] BLANK_LOAD = BLANK_CNT_W'(BLANK_CYCLES - 1);

  state_t                 state_reg;
  logic [1:0]             digit_idx_reg;
  logic                   scan_q_reg;
  logic [BLANK_CNT_W-1:0] blank_cnt_reg;
  logic [15:0]            shadow_value_reg;
  logic [3:0]             shadow_dp_reg;
  logic [3:0]             anode_n_reg;
  logic [6:0]             seg_n_reg;
  logic                   dp_n_reg;

  logic       tick;
  logic [3:0] nibble_sel;
  logic [6:0] seg_dec;
  logic [3:0] upper_zero;
  logic [3:0] anode_sel;
  logic       lz_blank;

  assign tick       = bus.scan_in & ~scan_q_reg;
  assign nibble_sel = shadow_value_reg[{digit_idx_reg, 2'b00} +: 4];

  // upper_zero[i]: nibbles i..3 of the frame snapshot are all zero
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign upper_zero[gi] = ~|shadow_value_reg[15:4*gi];
    assign anode_sel[gi]  = (digit_idx_reg != 2'(gi));
  end

  assign lz_blank = LZ_SUPPRESS && (digit_idx_reg != 2'd0) && upper_zero[digit_idx_reg];

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble_sel),
    .seg_n  (seg_dec)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      digit_idx_reg    <= 2'd3;
      scan_q_reg       <= 1'b1;
      blank_cnt_reg    <= '0;
      shadow_value_reg <= '0;
      shadow_dp_reg    <= '0;
      anode_n_reg      <= 4'hF;
      seg_n_reg        <= SEG_BLANK;
      dp_n_reg         <= 1'b1;
    end else begin
      scan_q_reg <= bus.scan_in;
      if (tick) begin
        // A tick in any state advances the digit and restarts the blank gap
        digit_idx_reg <= digit_idx_reg + 2'd1;
        blank_cnt_reg <= BLANK_LOAD;
        anode_n_reg   <= 4'hF;
        seg_n_reg     <= SEG_BLANK;
        dp_n_reg      <= 1'b1;
        state_reg     <= ST_BLANK;
        if (digit_idx_reg == 2'd3) begin
          shadow_value_reg <= bus.value;
          shadow_dp_reg    <= bus.dp_in;
        end
      end else begin
        case (state_reg)
          ST_BLANK: begin
            if (blank_cnt_reg == '0) begin
              state_reg   <= ST_SHOW;
              anode_n_reg <= anode_sel;
              seg_n_reg   <= lz_blank ? SEG_BLANK : seg_dec;
              dp_n_reg    <= ~shadow_dp_reg[digit_idx_reg];
            end else begin
              blank_cnt_reg <= blank_cnt_reg - BLANK_CNT_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.anode_n = anode_n_reg;
  assign bus.seg_n   = seg_n_reg;
  assign bus.dp_n    = dp_n_reg;

endmodule
